// File: rtl/psec6_acq_sequencer.sv
// PSEC6 acquisition/readout sequencer: arm, post-trigger stop delay,
// and a load/shift walk over every channel counter.
module psec6_acq_sequencer #(
  parameter int NUM_SEL   = 5,
  parameter int WORD_BITS = 16,
  parameter int DELAY_W   = 6
) (
  input  logic               spi_clk,
  input  logic               rst,
  input  logic               inst_start,
  input  logic               inst_readout,
  input  logic               inst_rst,
  input  logic               trigger_in,
  input  logic [DELAY_W-1:0] trigger_delay,
  input  logic               auto_rearm,
  output logic               clk_enable,
  output logic [2:0]         select_reg,
  output logic               load_strobe,
  output logic               shift_en,
  output logic               busy,
  output logic               acq_done,
  output logic [2:0]         state_dbg
);

  localparam int BW = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SAMPLING = 3'd1,
    S_DELAY    = 3'd2,
    S_HOLD     = 3'd3,
    S_LOAD     = 3'd4,
    S_SHIFT    = 3'd5,
    S_DONE     = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] dly_q, dly_d;
  logic [BW-1:0]      bit_q, bit_d;
  logic [2:0]         sel_q, sel_d;
  logic               trig_q;
  logic               trig_rise;
  logic               ce_q, ce_d;
  logic               ld_q, ld_d;
  logic               sh_q, sh_d;
  logic               bz_q, bz_d;
  logic               dn_q, dn_d;

  assign trig_rise = trigger_in & ~trig_q;

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    bit_d   = bit_q;
    sel_d   = sel_q;
    if (inst_rst) begin
      state_d = S_IDLE;
      dly_d   = '0;
      bit_d   = '0;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (inst_start) state_d = S_SAMPLING;
        end
        S_SAMPLING: begin
          if (trig_rise) begin
            dly_d   = trigger_delay;
            state_d = (trigger_delay == '0) ? S_HOLD : S_DELAY;
          end
        end
        S_DELAY: begin
          dly_d = dly_q - DELAY_W'(1);
          if (dly_q == DELAY_W'(1)) state_d = S_HOLD;
        end
        S_HOLD: begin
          if (inst_readout) begin
            state_d = S_LOAD;
            sel_d   = '0;
          end else if (inst_start) begin
            state_d = S_SAMPLING;
          end
        end
        S_LOAD: begin
          bit_d   = '0;
          state_d = S_SHIFT;
        end
        S_SHIFT: begin
          bit_d = bit_q + BW'(1);
          if (bit_q == BW'(WORD_BITS - 1)) begin
            if (sel_q < 3'(NUM_SEL - 1)) begin
              sel_d   = sel_q + 3'd1;
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_DONE: begin
          sel_d   = '0;
          state_d = auto_rearm ? S_SAMPLING : S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state so they register with it.
  always_comb begin
    ce_d = (state_d == S_SAMPLING) || (state_d == S_DELAY);
    ld_d = (state_d == S_LOAD);
    sh_d = (state_d == S_SHIFT);
    bz_d = (state_d != S_IDLE);
    dn_d = (state_d == S_DONE);
  end

  always_ff @(posedge spi_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      dly_q   <= '0;
      bit_q   <= '0;
      sel_q   <= '0;
      trig_q  <= 1'b0;
      ce_q    <= 1'b0;
      ld_q    <= 1'b0;
      sh_q    <= 1'b0;
      bz_q    <= 1'b0;
      dn_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      bit_q   <= bit_d;
      sel_q   <= sel_d;
      trig_q  <= trigger_in;
      ce_q    <= ce_d;
      ld_q    <= ld_d;
      sh_q    <= sh_d;
      bz_q    <= bz_d;
      dn_q    <= dn_d;
    end
  end

  assign clk_enable  = ce_q;
  assign select_reg  = sel_q;
  assign load_strobe = ld_q;
  assign shift_en    = sh_q;
  assign busy        = bz_q;
  assign acq_done    = dn_q;
  assign state_dbg   = state_q;

endmodule

// File: doc/psec6_acq_sequencer.md
Name: psec6_acq_sequencer

Overview:
Acquisition and readout sequencer for the PSEC6 digital core. It takes the instruction pulses decoded from SPI address 3 and the external trigger, and generates:
- the sampling `clk_enable`;
- a programmable post-trigger stop delay;
- a walk through every channel counter (`select_reg`) with load/shift strobes for the readout serializer.

It sits between the SPI register file / instruction driver and the clock blocks and channel digital.

Parameters:
NUM_SEL, 5, number of counters walked per readout (`select_reg` values 0..NUM_SEL-1, NUM_SEL <= 8)
WORD_BITS, 16, shift cycles per counter word (2..256)
DELAY_W, 6, width of `trigger_delay`

Ports:
spi_clk  input  1  sole clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
inst_start  input  1  single-cycle pulse: arm and start sampling
inst_readout  input  1  single-cycle pulse: begin counter readout
inst_rst  input  1  single-cycle pulse: abort to IDLE
trigger_in  input  1  external stop trigger, level, already synchronous to spi_clk
trigger_delay  input  DELAY_W  post-trigger cycles before sampling stops (address 8)
auto_rearm  input  1  1 = return to SAMPLING after readout instead of IDLE (`mode[0]`)
clk_enable  output  1  sampling clock enable to clock blocks
select_reg  output  3  counter select to channel digital
load_strobe  output  1  one-cycle capture of selected counter into serializer
shift_en  output  1  serializer shift enable
busy  output  1  high in every state except IDLE
acq_done  output  1  one-cycle pulse when readout of all counters completes
state_dbg  output  3  encoded FSM state for test point mux

Behaviour:
- Reset (`rst`=1 at a clock edge): state=IDLE; `clk_enable`=0, `select_reg`=0, `load_strobe`=0, `shift_en`=0, `busy`=0, `acq_done`=0; delay, bit and select counters=0; trigger edge register=0.
- All outputs are registered; each output reflects the state entered on the same edge.
- State encoding for `state_dbg`: IDLE=0, SAMPLING=1, DELAY=2, HOLD=3, LOAD=4, SHIFT=5, DONE=6.
- Trigger edge: `trig_prev` is a register of `trigger_in`. `trig_rise = trigger_in & ~trig_prev`. Edges are only acted on in SAMPLING; the edge register updates in all states.
- Priority at any edge: `rst` > `inst_rst` > state transition.
- `inst_rst` in any state: next state is IDLE, and all outputs and counters take their reset values.
- IDLE:
  - `inst_start` -> SAMPLING, `clk_enable`=1 on the next cycle.
  - `inst_readout` and trigger are ignored.
- SAMPLING:
  - `clk_enable`=1.
  - `trig_rise` latches `trigger_delay` into `dly_cnt`.
  - If the latched value is 0, go directly to HOLD, so `clk_enable` is 0 one cycle after the cycle in which the edge is seen. Otherwise go to DELAY.
  - `inst_start` and `inst_readout` are ignored.
- DELAY:
  - `clk_enable`=1; `dly_cnt` decrements each cycle.
  - When `dly_cnt`==1, go to HOLD. `clk_enable` therefore drops exactly D+1 cycles after the edge-sample cycle (D = latched delay; D=63 gives 64).
  - Further trigger edges and changes on `trigger_delay` are ignored.
- HOLD:
  - `clk_enable`=0; wait indefinitely.
  - `inst_readout` -> LOAD with `select_reg`=0.
  - `inst_start` in HOLD -> SAMPLING (discard and re-arm).
- LOAD:
  - One cycle; `load_strobe`=1, `shift_en`=0.
  - Bit counter cleared; next state is SHIFT.
- SHIFT:
  - `shift_en`=1 for exactly WORD_BITS consecutive cycles.
  - After the last bit: if `select_reg` < NUM_SEL-1, increment `select_reg` and go to LOAD. Otherwise go to DONE.
  - `select_reg` never wraps past NUM_SEL-1.
- DONE:
  - One cycle; `acq_done`=1.
  - `select_reg` returns to 0 on exit.
  - Next state is SAMPLING (`clk_enable`=1) if `auto_rearm`=1, otherwise IDLE. `auto_rearm` is sampled in this cycle only.
- Instruction pulses arriving in states not listed above are dropped, not queued.
- Total readout length: NUM_SEL*(WORD_BITS+1)+1 cycles from the first LOAD through DONE (default 86).
- `trigger_in` held high across an `inst_start` does not stop sampling; a fresh rising edge is required.

Test Plan:
- Reset then idle: `rst`=1 for 2 cycles, then pulse `inst_readout` and toggle `trigger_in` -> state stays IDLE, all outputs 0.
- Delay timing: `inst_start`, then `trigger_delay`=5 and a `trigger_in` rise -> `clk_enable` stays 1 for 6 cycles after the edge-sample cycle, then 0; `state_dbg` follows 1->2->3. Repeat with `trigger_delay`=0 -> `clk_enable`=0 one cycle after the edge; `trigger_delay`=63 -> 64 cycles.
- Full readout (defaults): HOLD, then `inst_readout`:
  - 5 `load_strobe` pulses with `select_reg` 0,1,2,3,4, each followed by exactly 16 `shift_en` cycles;
  - `acq_done` on cycle 86;
  - `select_reg` then 0 and state IDLE.
- Auto re-arm: `auto_rearm`=1 at DONE -> `clk_enable`=1 the cycle after `acq_done`, state SAMPLING. A second trigger and readout cycle completes identically.
- Abort/priority:
  - `inst_rst` mid-SHIFT (counter 2, bit 7) -> next cycle IDLE, `shift_en`=0, `select_reg`=0.
  - `inst_rst` and `inst_readout` in the same HOLD cycle -> IDLE.
  - `rst` and `inst_start` together -> IDLE.
- Ignored events: `inst_readout` during SAMPLING, second trigger edge during DELAY, and `trigger_in` held high across `inst_start` -> no state change beyond the nominal sequence, and `clk_enable` stays 1 until a fresh edge.
